// File: rtl/stream_raster_src.sv
// Raster stream source: walks a full frame (active + blanking) in raster order,
// pulling active pixels from a valid/ready upstream and stalling when it underruns.
module stream_raster_src #(
   parameter int BIT_WIDTH    = 8,
   parameter int IMAGE_HEIGHT = 480,
   parameter int IMAGE_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 525,
   parameter int FRAME_WIDTH  = 800,
   parameter int CONTINUOUS   = 0,
   localparam int VW = $clog2(FRAME_HEIGHT),
   localparam int HW = $clog2(FRAME_WIDTH)
) (
   input  logic                 clock,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic                 ds_ready,
   input  logic                 in_valid,
   input  logic [BIT_WIDTH-1:0] in_pixel,
   output logic                 in_ready,
   output logic                 out_enable,
   output logic [BIT_WIDTH-1:0] out_pixel,
   output logic [VW-1:0]        out_vcnt,
   output logic [HW-1:0]        out_hcnt,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          stall_cnt
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t               r_state;
   logic [VW-1:0]        r_v;
   logic [HW-1:0]        r_h;
   logic                 r_en;
   logic [BIT_WIDTH-1:0] r_pix;
   logic [VW-1:0]        r_ov;
   logic [HW-1:0]        r_oh;
   logic                 r_busy;
   logic                 r_fd;
   logic [15:0]          r_stall;

   logic w_run, w_active, w_adv, w_under, w_last_h, w_last_v;

   // Limits are cast to the counter width; they always fit since IMAGE < FRAME <= 2**W.
   assign w_run    = (r_state == S_RUN);
   assign w_active = (r_v < VW'(IMAGE_HEIGHT)) && (r_h < HW'(IMAGE_WIDTH));
   assign w_last_h = (r_h == HW'(FRAME_WIDTH - 1));
   assign w_last_v = (r_v == VW'(FRAME_HEIGHT - 1));
   assign w_adv    = w_run && ds_ready && (!w_active || in_valid);
   assign w_under  = w_run && ds_ready && w_active && !in_valid;

   assign in_ready   = w_run && ds_ready && w_active;
   assign out_enable = r_en;
   assign out_pixel  = r_pix;
   assign out_vcnt   = r_ov;
   assign out_hcnt   = r_oh;
   assign busy       = r_busy;
   assign frame_done = r_fd;
   assign stall_cnt  = r_stall;

   always_ff @(posedge clock) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
         r_v     <= '0;
         r_h     <= '0;
         r_en    <= 1'b0;
         r_pix   <= '0;
         r_ov    <= '0;
         r_oh    <= '0;
         r_busy  <= 1'b0;
         r_fd    <= 1'b0;
         r_stall <= '0;
      end else begin
         r_en <= 1'b0;
         r_fd <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_v     <= '0;
                  r_h     <= '0;
                  r_stall <= '0;
               end
            end
            S_RUN: begin
               if (w_adv) begin
                  r_en  <= 1'b1;
                  r_pix <= w_active ? in_pixel : '0;
                  r_ov  <= r_v;
                  r_oh  <= r_h;
                  if (w_last_h) begin
                     r_h <= '0;
                     if (w_last_v) begin
                        r_v  <= '0;
                        r_fd <= 1'b1;
                        // Frame boundary: one-shot returns to idle, continuous mode restarts the underrun count.
                        if (CONTINUOUS == 0) begin
                           r_state <= S_IDLE;
                           r_busy  <= 1'b0;
                        end else begin
                           r_stall <= '0;
                        end
                     end else begin
                        r_v <= r_v + 1'b1;
                     end
                  end else begin
                     r_h <= r_h + 1'b1;
                  end
               end else if (w_under && r_stall != 16'hFFFF) begin
                  r_stall <= r_stall + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_raster_src.sv
// Bench for stream_raster_src on a 4x3 image inside a 6x4 frame; one one-shot and one continuous instance.
module tb_stream_raster_src;

   typedef struct packed {
      logic [1:0] v;
      logic [2:0] h;
      logic [7:0] p;
   } beat_t;

   logic       clock = 1'b0;
   logic       n_rst0, n_rst1, start0, start1, ds_ready, in_valid;
   logic [7:0] in_pixel, pix_base;
   int         acc_cnt = 0;

   logic       in_ready0, out_enable0, busy0, frame_done0;
   logic [7:0] out_pixel0;
   logic [1:0] out_vcnt0;
   logic [2:0] out_hcnt0;
   logic [15:0] stall_cnt0;

   logic       in_ready1, out_enable1, busy1, frame_done1;
   logic [7:0] out_pixel1;
   logic [1:0] out_vcnt1;
   logic [2:0] out_hcnt1;
   logic [15:0] stall_cnt1;

   int    n_chk = 0, n_pass = 0, n_fail = 0;
   int    fd0 = 0, fd1 = 0;
   bit    mon_on = 1'b0;
   beat_t q0[$], q1[$];
   beat_t b0, b1;
   logic  hs;

   always #5 clock = ~clock;

   assign in_pixel = pix_base + acc_cnt[7:0];

   stream_raster_src #(.BIT_WIDTH(8), .IMAGE_HEIGHT(3), .IMAGE_WIDTH(4),
                       .FRAME_HEIGHT(4), .FRAME_WIDTH(6), .CONTINUOUS(0)) u0 (
      .clock(clock), .n_rst(n_rst0), .start(start0), .ds_ready(ds_ready),
      .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready0),
      .out_enable(out_enable0), .out_pixel(out_pixel0), .out_vcnt(out_vcnt0),
      .out_hcnt(out_hcnt0), .busy(busy0), .frame_done(frame_done0), .stall_cnt(stall_cnt0));

   stream_raster_src #(.BIT_WIDTH(8), .IMAGE_HEIGHT(3), .IMAGE_WIDTH(4),
                       .FRAME_HEIGHT(4), .FRAME_WIDTH(6), .CONTINUOUS(1)) u1 (
      .clock(clock), .n_rst(n_rst1), .start(start1), .ds_ready(ds_ready),
      .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready1),
      .out_enable(out_enable1), .out_pixel(out_pixel1), .out_vcnt(out_vcnt1),
      .out_hcnt(out_hcnt1), .busy(busy1), .frame_done(frame_done1), .stall_cnt(stall_cnt1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Expected beats of one frame in raster order; active pixels numbered from base.
   task automatic push_frame(input int sel, input int base);
      beat_t b;
      int    p = base;
      for (int v = 0; v < 4; v++)
         for (int h = 0; h < 6; h++) begin
            b.v = 2'(v);
            b.h = 3'(h);
            if (v < 3 && h < 4) begin b.p = 8'(p); p++; end
            else b.p = 8'd0;
            if (sel == 0) q0.push_back(b); else q1.push_back(b);
         end
   endtask

   task automatic wait_beat(input int sel, input int v, input int h, input string tag);
      bit found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (sel == 0 ? (out_enable0 && out_vcnt0 == 2'(v) && out_hcnt0 == 3'(h))
                      : (out_enable1 && out_vcnt1 == 2'(v) && out_hcnt1 == 3'(h))) begin
            found = 1'b1;
            break;
         end
         tick(1);
      end
      chk(tag, found, 1);
   endtask

   // Upstream source: handshake is sampled mid-cycle, next pixel presented after the edge.
   always begin
      @(negedge clock);
      hs = in_valid && (in_ready0 || in_ready1);
      @(posedge clock);
      #1;
      if (hs) acc_cnt++;
   end

   always @(negedge clock) if (mon_on) begin
      if (out_enable0) begin
         if (q0.size() == 0) chk("u0_extra_beat", 1, 0);
         else begin
            b0 = q0.pop_front();
            chk("u0_vcnt", out_vcnt0, b0.v);
            chk("u0_hcnt", out_hcnt0, b0.h);
            chk("u0_pixel", out_pixel0, b0.p);
            chk("u0_frame_done", frame_done0, (b0.v == 2'd3 && b0.h == 3'd5));
            if (frame_done0) fd0++;
         end
      end else chk("u0_fd_no_beat", frame_done0, 0);
   end

   always @(negedge clock) if (mon_on) begin
      if (out_enable1) begin
         if (q1.size() == 0) chk("u1_extra_beat", 1, 0);
         else begin
            b1 = q1.pop_front();
            chk("u1_vcnt", out_vcnt1, b1.v);
            chk("u1_hcnt", out_hcnt1, b1.h);
            chk("u1_pixel", out_pixel1, b1.p);
            chk("u1_frame_done", frame_done1, (b1.v == 2'd3 && b1.h == 3'd5));
            if (frame_done1) fd1++;
         end
      end else chk("u1_fd_no_beat", frame_done1, 0);
   end

   initial begin
      int k;
      n_rst0 = 0; n_rst1 = 0; start0 = 0; start1 = 0;
      ds_ready = 1; in_valid = 1; pix_base = 8'd1;
      tick(2);
      chk("rst_enable", out_enable0, 0);
      chk("rst_pixel", out_pixel0, 0);
      chk("rst_pos", {out_vcnt0, out_hcnt0}, 0);
      chk("rst_busy_fd", {busy0, frame_done0}, 0);
      chk("rst_stall", stall_cnt0, 0);
      chk("idle_in_ready", in_ready0, 0);
      n_rst0 = 1; n_rst1 = 1; mon_on = 1'b1;
      tick(1);

      // 1: clean frame, 24 back-to-back beats
      pix_base = 8'(1 - acc_cnt);
      push_frame(0, 1);
      start0 = 1; tick(1); start0 = 0;
      chk("s1_busy_rise", busy0, 1);
      for (k = 0; k < 100 && busy0; k++) tick(1);
      chk("s1_frame_cycles", k, 24);
      chk("s1_stall", stall_cnt0, 0);
      tick(1);
      chk("s1_queue_empty", q0.size(), 0);
      chk("s1_fd_count", fd0, 1);

      // 2: five-cycle underrun at (1,2)
      pix_base = 8'(1 - acc_cnt);
      push_frame(0, 1);
      start0 = 1; tick(1); start0 = 0;
      wait_beat(0, 1, 1, "s2_reach_1_1");
      in_valid = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("s2_hold_enable", out_enable0, 0);
         chk("s2_hold_pos", {out_vcnt0, out_hcnt0}, {2'd1, 3'd1});
      end
      chk("s2_stall5", stall_cnt0, 5);
      in_valid = 1;
      for (k = 0; k < 100 && busy0; k++) tick(1);
      tick(1);
      chk("s2_stall_kept", stall_cnt0, 5);
      chk("s2_queue_empty", q0.size(), 0);
      chk("s2_fd_count", fd0, 2);

      // 3: downstream stall in blanking at (0,4)
      pix_base = 8'(1 - acc_cnt);
      push_frame(0, 1);
      start0 = 1; tick(1); start0 = 0;
      chk("s3_stall_cleared", stall_cnt0, 0);
      wait_beat(0, 0, 3, "s3_reach_0_3");
      ds_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("s3_no_beat", out_enable0, 0);
         chk("s3_in_ready", in_ready0, 0);
      end
      chk("s3_stall", stall_cnt0, 0);
      ds_ready = 1;
      for (k = 0; k < 100 && busy0; k++) tick(1);
      tick(1);
      chk("s3_queue_empty", q0.size(), 0);

      // 5: reset mid-frame at (2,1), then a clean restart
      pix_base = 8'(1 - acc_cnt);
      push_frame(0, 1);
      start0 = 1; tick(1); start0 = 0;
      wait_beat(0, 2, 0, "s5_reach_2_0");
      n_rst0 = 0; tick(1);
      chk("s5_rst_enable", out_enable0, 0);
      chk("s5_rst_outs", {out_pixel0, out_vcnt0, out_hcnt0}, 0);
      chk("s5_rst_busy_fd", {busy0, frame_done0}, 0);
      chk("s5_rst_stall", stall_cnt0, 0);
      q0.delete();
      n_rst0 = 1; tick(1);
      chk("s5_no_fd", fd0, 3);
      pix_base = 8'(1 - acc_cnt);
      push_frame(0, 1);
      start0 = 1; tick(1); start0 = 0;
      tick(1);
      chk("s5_restart_pos", {out_enable0, out_vcnt0, out_hcnt0}, {1'b1, 2'd0, 3'd0});
      for (k = 0; k < 100 && busy0; k++) tick(1);
      tick(1);
      chk("s5_queue_empty", q0.size(), 0);

      // 6: start held high through a frame
      pix_base = 8'(1 - acc_cnt);
      push_frame(0, 1);
      start0 = 1; tick(1);
      for (k = 0; k < 100 && busy0; k++) tick(1);
      chk("s6_single_frame", k, 24);
      chk("s6_busy_fell", busy0, 0);
      tick(1);
      chk("s6_rearm", busy0, 1);
      chk("s6_queue_empty", q0.size(), 0);
      n_rst0 = 0; start0 = 0; tick(1);
      n_rst0 = 1; tick(1);

      // 4: continuous mode, two frames, underrun in frame 1
      pix_base = 8'(1 - acc_cnt);
      push_frame(1, 1);
      push_frame(1, 13);
      start1 = 1; tick(1); start1 = 0;
      wait_beat(1, 0, 0, "s4_reach_0_0");
      in_valid = 0; tick(2);
      chk("s4_stall2", stall_cnt1, 2);
      in_valid = 1;
      for (k = 0; k < 100 && !frame_done1; k++) tick(1);
      chk("s4_fd1_seen", frame_done1, 1);
      chk("s4_stall_wrap", stall_cnt1, 0);
      chk("s4_busy_wrap", busy1, 1);
      tick(1);
      chk("s4_no_gap", {out_enable1, out_vcnt1, out_hcnt1}, {1'b1, 2'd0, 3'd0});
      for (k = 0; k < 100 && !frame_done1; k++) tick(1);
      chk("s4_fd2_seen", frame_done1, 1);
      chk("s4_busy_stays", busy1, 1);
      n_rst1 = 0; tick(1);
      chk("s4_queue_empty", q1.size(), 0);
      chk("s4_fd_count", fd1, 2);
      n_rst1 = 1; tick(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/stream_raster_src.md
Name: stream_raster_src

Overview:
- Raster stream source: the producer end of the pixel/vcnt/hcnt stream interface consumed by the patch extractor and other stream blocks.
- Pulls active-image pixels from an upstream valid/ready source, such as a frame-buffer reader or FIFO.
- Emits one pixel per advance in raster order, including blanking positions, with matching vcnt/hcnt and a per-cycle enable that drives downstream stall logic.
- Stalls the whole stream, holding counters, whenever an active pixel is needed but unavailable, or when downstream is not ready.

Parameters:
- BIT_WIDTH, 8, pixel bit width.
- IMAGE_HEIGHT, 480, active lines per frame.
- IMAGE_WIDTH, 640, active pixels per line.
- FRAME_HEIGHT, 525, total lines including blanking (must be > IMAGE_HEIGHT).
- FRAME_WIDTH, 800, total pixels per line including blanking (must be > IMAGE_WIDTH).
- CONTINUOUS, 0, 1 = wrap to the next frame automatically; 0 = stop after one frame.

Ports:
- clock, input, 1, system clock.
- n_rst, input, 1, reset, synchronous and active-low.
- start, input, 1, begins a frame when idle; ignored while running.
- ds_ready, input, 1, downstream can accept a stream beat this cycle.
- in_valid, input, 1, upstream pixel valid.
- in_pixel, input, BIT_WIDTH, upstream pixel data.
- in_ready, output, 1, combinational; pixel accepted when in_valid && in_ready.
- out_enable, output, 1, registered; output beat valid this cycle.
- out_pixel, output, BIT_WIDTH, registered pixel; 0 at blanking positions.
- out_vcnt, output, log2(FRAME_HEIGHT), registered line index.
- out_hcnt, output, log2(FRAME_WIDTH), registered pixel index.
- busy, output, 1, registered; high while in RUN.
- frame_done, output, 1, registered one-cycle pulse accompanying the beat at (FRAME_HEIGHT-1, FRAME_WIDTH-1).
- stall_cnt, output, 16, saturating count of underrun cycles in the current frame.

Behaviour:
- log2 is ceil(log2(x)), as used throughout the codebase.
- Reset (n_rst=0 at a clock edge):
  - state := IDLE; internal counters v,h := 0.
  - All outputs := 0, including stall_cnt.
  - Reset mid-frame abandons the frame; no frame_done is issued.
- States: IDLE, RUN.
  - IDLE -> RUN on start=1. Sets v=h=0 and clears stall_cnt.
  - RUN -> IDLE after the advance at (FRAME_HEIGHT-1, FRAME_WIDTH-1) when CONTINUOUS=0.
  - When CONTINUOUS=1, RUN wraps to (0,0) and remains in RUN. stall_cnt clears at wrap.
- Position classification: active = (v < IMAGE_HEIGHT) && (h < IMAGE_WIDTH).
- Combinational: in_ready = RUN && ds_ready && active.
- Advance condition: adv = RUN && ds_ready && (!active || in_valid).
- On adv:
  - out_enable := 1.
  - out_pixel := active ? in_pixel : 0.
  - out_vcnt := v; out_hcnt := h.
  - h := h+1, or 0 with v := v+1 when h = FRAME_WIDTH-1.
  - v wraps to 0 after FRAME_HEIGHT-1.
- Without adv: out_enable := 0. out_pixel/out_vcnt/out_hcnt hold their last values. Counters hold.
- Latency: pixel accepted at edge t is presented at t+1 with out_enable=1. The upstream handshake and the output beat are 1:1 for active positions.
- Blanking positions advance with only ds_ready required; in_valid and in_pixel are ignored.
- Underrun: RUN && ds_ready && active && !in_valid increments stall_cnt, saturating at 65535. ds_ready=0 is not counted.
- frame_done := 1 exactly on the edge producing the last-position beat, 0 otherwise.
- busy := (next state == RUN).
- start while RUN is ignored. start on the same edge that the frame completes (CONTINUOUS=0) is ignored; the next start must come at least one cycle after busy falls.
- No pixel is consumed in IDLE (in_ready=0).
- Width rules: counters compare against parameters at full log2 width. No truncation is permitted for FRAME_WIDTH a power of two, e.g. 8 gives a 3-bit h that wraps exactly.

Test Plan:
Reduced test parameters: IMAGE 4x3 (W x H), FRAME 6x4, BIT_WIDTH=8, CONTINUOUS=0.
1. Reset, start pulse, in_valid=1, in_pixel = incrementing 1..12, ds_ready=1 → 24 consecutive beats with out_enable=1. Pixels 1..12 appear at h<4, v<3; zeros elsewhere. frame_done pulses with (3,5). busy falls after the 24th beat. stall_cnt=0.
2. Same as scenario 1, but in_valid=0 for 5 cycles at position (1,2) → out_enable low for 5 cycles; out_vcnt/out_hcnt hold at (1,1); stall_cnt=5. The stream then resumes with the correct pixel at (1,2).
3. ds_ready=0 for 3 cycles during blanking (0,4) → no beats during those cycles; stall_cnt unchanged; in_ready=0 throughout.
4. CONTINUOUS=1, two frames → beat after (3,5) is (0,0) with no gap; frame_done pulses twice; busy stays 1; stall_cnt clears at the wrap.
5. Assert n_rst=0 at position (2,1) → next cycle: all outputs 0, state IDLE, no frame_done. A new start restarts at (0,0).
6. start held high throughout a frame (CONTINUOUS=0) → single frame only until busy=0; re-arm occurs only on the cycle after busy falls.
